// File: rtl/bram_ring_ctrl_pkg.sv
// Shared definitions for the BRAM ring-buffer controller: state encoding,
// default geometry and the layout of the status register.
package bram_ring_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RUN      = 2'd1,
    STOPPING = 2'd2,
    FLUSH    = 2'd3
  } state_t;

  localparam int DEF_DEPTH_WORDS  = 16384;
  localparam int DEF_PTR_W        = 14;
  localparam int DEF_PACKET_WORDS = 144;

  localparam int STAT_STATE_LSB   = 0;
  localparam int STAT_OVERRUN_BIT = 2;
  localparam int STAT_RD_ERR_BIT  = 3;

  function automatic logic [3:0] status_word(state_t st, logic ovr, logic rerr);
    logic [3:0] w;
    w = '0;
    w[STAT_STATE_LSB +: 2]  = st;
    w[STAT_OVERRUN_BIT]     = ovr;
    w[STAT_RD_ERR_BIT]      = rerr;
    return w;
  endfunction

endpackage

// File: rtl/bram_ring_ctrl_if.sv
// Control/status bundle between the ring controller, the FIFO-BRAM writer,
// the data generator and the PS register block.
interface bram_ring_ctrl_if
  import bram_ring_ctrl_pkg::*;
#(
  parameter int PTR_W = DEF_PTR_W
);
  logic             start_req;
  logic             stop_req;
  logic             clr_err;
  logic             wr_commit;
  logic [8:0]       fifo_count;
  logic             rd_ptr_upd;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   irq_thresh;
  logic             gen_enable;
  logic             buf_reset;
  logic [PTR_W:0]   fill_level;
  logic             irq;
  logic             overrun;
  logic             rd_err;
  logic [1:0]       state;

  modport master (
    output start_req, stop_req, clr_err, wr_commit, fifo_count,
           rd_ptr_upd, rd_ptr, irq_thresh,
    input  gen_enable, buf_reset, fill_level, irq, overrun, rd_err, state
  );

  modport slave (
    input  start_req, stop_req, clr_err, wr_commit, fifo_count,
           rd_ptr_upd, rd_ptr, irq_thresh,
    output gen_enable, buf_reset, fill_level, irq, overrun, rd_err, state
  );
endinterface

// File: rtl/bram_ring_ctrl_ring_fill_tracker.sv
// Fill-level bookkeeping for the ring: adds committed words, subtracts words
// consumed by the PS (modulo ring depth) and flags underflow / saturation.
module ring_fill_tracker
  import bram_ring_ctrl_pkg::*;
#(
  parameter int DEPTH_WORDS = DEF_DEPTH_WORDS,
  parameter int PTR_W       = DEF_PTR_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             track,
  input  logic             clear,
  input  logic             wr_commit,
  input  logic             rd_ptr_upd,
  input  logic [PTR_W-1:0] rd_ptr,
  output logic [PTR_W:0]   fill_level,
  output logic             overrun_evt,
  output logic             rd_err_evt
);
  localparam int W2 = PTR_W + 2;
  localparam int W1 = PTR_W + 1;
  localparam logic [W2-1:0] FULL_W2 = W2'(DEPTH_WORDS);
  localparam logic [W1-1:0] FULL    = W1'(DEPTH_WORDS);

  logic [PTR_W-1:0] rd_ptr_q;
  logic [PTR_W-1:0] consumed;
  logic [W2-1:0]    total;
  logic [W2-1:0]    remain;

  // Depth is a power of two, so the PTR_W-bit difference is already mod depth.
  always_comb begin
    consumed    = rd_ptr_upd ? (rd_ptr - rd_ptr_q) : '0;
    total       = W2'(fill_level) + W2'(wr_commit);
    remain      = total - W2'(consumed);
    rd_err_evt  = track && !clear && (W2'(consumed) > total);
    overrun_evt = track && !clear && !rd_err_evt && (remain > FULL_W2);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fill_level <= '0;
      rd_ptr_q   <= '0;
    end else if (clear) begin
      fill_level <= '0;
      rd_ptr_q   <= '0;
    end else begin
      if (rd_ptr_upd) rd_ptr_q <= rd_ptr;
      if (track) begin
        if (rd_err_evt)       fill_level <= '0;
        else if (overrun_evt) fill_level <= FULL;
        else                  fill_level <= remain[W1-1:0];
      end
    end
  end

endmodule

// File: rtl/bram_ring_ctrl.sv
// Acquisition controller for a BRAM ring buffer: start/stop FSM with
// packet-aligned stop, overrun protection, sticky error flags and level irq.
module bram_ring_ctrl
  import bram_ring_ctrl_pkg::*;
#(
  parameter int DEPTH_WORDS  = DEF_DEPTH_WORDS,
  parameter int PTR_W        = DEF_PTR_W,
  parameter int PACKET_WORDS = DEF_PACKET_WORDS
) (
  input logic             clk,
  input logic             rst,
  bram_ring_ctrl_if.slave bus
);
  localparam int CNT_W  = $clog2(PACKET_WORDS);
  localparam int FILL_W = PTR_W + 1;
  localparam logic [FILL_W-1:0] OVR_LIMIT = FILL_W'(DEPTH_WORDS - PACKET_WORDS);
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(PACKET_WORDS - 1);

  state_t             st, st_nxt;
  logic [CNT_W-1:0]   word_cnt;
  logic [FILL_W-1:0]  fill;
  logic               boundary, start_ok, ovr_hit;
  logic               gen_d, irq_d, ov_set, re_set;
  logic               gen_enable, buf_reset, irq, overrun, rd_err;
  logic               overrun_evt, rd_err_evt;

  assign boundary = (word_cnt == '0) && !bus.wr_commit;
  assign start_ok = (st == IDLE) && bus.start_req && !bus.stop_req && !overrun && !rd_err;
  // Overrun guard: not enough room left for another whole packet.
  assign ovr_hit  = (st == RUN) && boundary && (fill > OVR_LIMIT);

  ring_fill_tracker #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .PTR_W       (PTR_W)
  ) u_fill (
    .clk         (clk),
    .rst         (rst),
    .track       (st != IDLE),
    .clear       (start_ok),
    .wr_commit   (bus.wr_commit),
    .rd_ptr_upd  (bus.rd_ptr_upd),
    .rd_ptr      (bus.rd_ptr),
    .fill_level  (fill),
    .overrun_evt (overrun_evt),
    .rd_err_evt  (rd_err_evt)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) st <= IDLE;
    else     st <= st_nxt;
  end

  always_comb begin
    st_nxt = st;
    case (st)
      IDLE:     if (start_ok) st_nxt = RUN;
      RUN:      if (ovr_hit) st_nxt = FLUSH;
                else if (bus.stop_req) st_nxt = STOPPING;
      STOPPING: if (boundary) st_nxt = FLUSH;
      FLUSH:    if ((bus.fifo_count == '0) && !bus.wr_commit) st_nxt = IDLE;
      default:  st_nxt = IDLE;
    endcase
  end

  always_comb begin
    gen_d  = (st_nxt == RUN) || (st_nxt == STOPPING);
    irq_d  = (st != IDLE) && (bus.irq_thresh != '0) && (fill >= bus.irq_thresh);
    ov_set = ovr_hit || overrun_evt;
    re_set = rd_err_evt;
  end

  // Sticky flags: a new error in the same cycle as clr_err wins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word_cnt   <= '0;
      gen_enable <= 1'b0;
      buf_reset  <= 1'b0;
      irq        <= 1'b0;
      overrun    <= 1'b0;
      rd_err     <= 1'b0;
    end else begin
      if (start_ok)           word_cnt <= '0;
      else if (bus.wr_commit) word_cnt <= (word_cnt == CNT_LAST) ? '0 : word_cnt + 1'b1;
      gen_enable <= gen_d;
      buf_reset  <= start_ok;
      irq        <= irq_d;
      if (ov_set)           overrun <= 1'b1;
      else if (bus.clr_err) overrun <= 1'b0;
      if (re_set)           rd_err  <= 1'b1;
      else if (bus.clr_err) rd_err  <= 1'b0;
    end
  end

  assign bus.gen_enable = gen_enable;
  assign bus.buf_reset  = buf_reset;
  assign bus.fill_level = fill;
  assign bus.irq        = irq;
  assign bus.overrun    = overrun;
  assign bus.rd_err     = rd_err;
  assign bus.state      = st;

endmodule

// File: tb/tb_bram_ring_ctrl.sv
// Bench for bram_ring_ctrl: directed scenarios plus random traffic, each cycle
// compared against an integer-arithmetic model of the controller's rules.
module tb_bram_ring_ctrl;
  localparam int D  = 16384;
  localparam int PW = 144;

  logic clk;
  logic rst;
  int   n_checks = 0;
  int   n_pass   = 0;

  int m_st, m_fill, m_rdq, m_cnt;
  bit m_ov, m_re, m_gen, m_buf, m_irq;

  bram_ring_ctrl_if #(.PTR_W(14)) bus ();

  bram_ring_ctrl #(
    .DEPTH_WORDS  (D),
    .PTR_W        (14),
    .PACKET_WORDS (PW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: observed %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
  endtask

  task automatic model_reset();
    m_st = 0; m_fill = 0; m_rdq = 0; m_cnt = 0;
    m_ov = 0; m_re = 0; m_gen = 0; m_buf = 0; m_irq = 0;
  endtask

  // One clock of the controller's rules, computed from the inputs being driven.
  task automatic model_step();
    int cons, tot, nst;
    bit start, bnd, ovh, ov_e, re_e;
    start = (m_st == 0) && bus.start_req && !bus.stop_req && !m_ov && !m_re;
    bnd   = (m_cnt == 0) && !bus.wr_commit;
    m_irq = (m_st != 0) && (bus.irq_thresh != 0) && (m_fill >= int'(bus.irq_thresh));
    ovh   = (m_st == 1) && bnd && (m_fill > D - PW);
    ov_e  = 0;
    re_e  = 0;
    if (start) begin
      m_fill = 0;
      m_rdq  = 0;
    end else begin
      cons = bus.rd_ptr_upd ? (int'(bus.rd_ptr) - m_rdq + D) % D : 0;
      if (bus.rd_ptr_upd) m_rdq = int'(bus.rd_ptr);
      if (m_st != 0) begin
        tot = m_fill + int'(bus.wr_commit);
        if (cons > tot) begin m_fill = 0; re_e = 1; end
        else if (tot - cons > D) begin m_fill = D; ov_e = 1; end
        else m_fill = tot - cons;
      end
    end
    if (start) m_cnt = 0;
    else if (bus.wr_commit) m_cnt = (m_cnt + 1) % PW;
    nst = m_st;
    case (m_st)
      0: if (start) nst = 1;
      1: if (ovh) nst = 3; else if (bus.stop_req) nst = 2;
      2: if (bnd) nst = 3;
      default: if (bus.fifo_count == 0 && !bus.wr_commit) nst = 0;
    endcase
    m_st  = nst;
    m_gen = (nst == 1) || (nst == 2);
    m_buf = start;
    if (ov_e || ovh) m_ov = 1; else if (bus.clr_err) m_ov = 0;
    if (re_e) m_re = 1; else if (bus.clr_err) m_re = 0;
  endtask

  task automatic compare_all();
    check("state", int'(bus.state), m_st);
    check("fill_level", int'(bus.fill_level), m_fill);
    check("gen_enable", int'(bus.gen_enable), int'(m_gen));
    check("buf_reset", int'(bus.buf_reset), int'(m_buf));
    check("irq", int'(bus.irq), int'(m_irq));
    check("overrun", int'(bus.overrun), int'(m_ov));
    check("rd_err", int'(bus.rd_err), int'(m_re));
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    compare_all();
    bus.start_req  = 1'b0;
    bus.stop_req   = 1'b0;
    bus.clr_err    = 1'b0;
    bus.wr_commit  = 1'b0;
    bus.rd_ptr_upd = 1'b0;
  endtask

  task automatic commit_n(input int n);
    for (int i = 0; i < n; i++) begin
      bus.wr_commit = 1'b1;
      tick();
    end
  endtask

  task automatic upd(input int rp);
    bus.rd_ptr     = 14'(rp);
    bus.rd_ptr_upd = 1'b1;
    tick();
  endtask

  task automatic start();
    bus.start_req = 1'b1;
    tick();
  endtask

  task automatic stop_and_drain();
    int guard;
    guard = 0;
    bus.fifo_count = 9'd0;
    if (m_st == 1) begin
      bus.stop_req = 1'b1;
      tick();
    end
    while (m_st != 0 && guard < 1000) begin
      bus.wr_commit = (m_cnt != 0);
      tick();
      guard++;
    end
    check("drain_to_idle", int'(bus.state), 0);
  endtask

  initial begin
    rst            = 1'b1;
    bus.start_req  = 1'b0;
    bus.stop_req   = 1'b0;
    bus.clr_err    = 1'b0;
    bus.wr_commit  = 1'b0;
    bus.fifo_count = 9'd0;
    bus.rd_ptr_upd = 1'b0;
    bus.rd_ptr     = 14'd0;
    bus.irq_thresh = 15'd0;
    model_reset();

    repeat (2) @(posedge clk);
    #1;
    compare_all();
    @(negedge clk);
    rst = 1'b0;

    // Nominal run
    start();
    check("nom_buf_reset", int'(bus.buf_reset), 1);
    check("nom_state_run", int'(bus.state), 1);
    tick();
    check("nom_buf_reset_drop", int'(bus.buf_reset), 0);
    commit_n(288);
    check("nom_fill_288", int'(bus.fill_level), 288);
    upd(144);
    check("nom_fill_144", int'(bus.fill_level), 144);
    check("nom_state", int'(bus.state), 1);
    stop_and_drain();

    // Stop mid-packet
    start();
    commit_n(150);
    bus.stop_req = 1'b1;
    tick();
    commit_n(138);
    check("stop_gen_held", int'(bus.gen_enable), 1);
    check("stop_state_stopping", int'(bus.state), 2);
    bus.fifo_count = 9'd5;
    tick();
    check("stop_state_flush", int'(bus.state), 3);
    check("stop_gen_drop", int'(bus.gen_enable), 0);
    repeat (3) tick();
    check("flush_wait", int'(bus.state), 3);
    bus.fifo_count = 9'd0;
    tick();
    check("flush_idle", int'(bus.state), 0);

    // Read error and clear priority
    start();
    commit_n(10);
    upd(20);
    check("rderr_fill", int'(bus.fill_level), 0);
    check("rderr_flag", int'(bus.rd_err), 1);
    bus.clr_err = 1'b1;
    upd(40);
    check("rderr_set_wins", int'(bus.rd_err), 1);
    bus.clr_err = 1'b1;
    tick();
    check("rderr_cleared", int'(bus.rd_err), 0);
    stop_and_drain();

    // Pointer wrap with simultaneous commit
    start();
    commit_n(16300);
    upd(16300);
    commit_n(180);
    upd(16380);
    check("wrap_fill_100", int'(bus.fill_level), 100);
    bus.wr_commit = 1'b1;
    upd(4);
    check("wrap_fill_93", int'(bus.fill_level), 93);
    stop_and_drain();

    // Overrun at packet boundary, start blocked until clr_err
    start();
    for (int k = 0; k < 113; k++) begin
      commit_n(PW);
      tick();
    end
    check("ovr_flag", int'(bus.overrun), 1);
    check("ovr_gen", int'(bus.gen_enable), 0);
    check("ovr_state", int'(bus.state), 3);
    tick();
    check("ovr_idle", int'(bus.state), 0);
    start();
    check("ovr_start_blocked", int'(bus.state), 0);
    bus.clr_err = 1'b1;
    tick();
    check("ovr_cleared", int'(bus.overrun), 0);
    start();
    check("ovr_restart", int'(bus.state), 1);

    // Saturation at full depth
    commit_n(D);
    check("sat_fill_full", int'(bus.fill_level), D);
    check("sat_no_ovr_yet", int'(bus.overrun), 0);
    commit_n(1);
    check("sat_fill_hold", int'(bus.fill_level), D);
    check("sat_ovr", int'(bus.overrun), 1);
    stop_and_drain();
    bus.clr_err = 1'b1;
    tick();

    // Random traffic
    for (int i = 0; i < 4000; i++) begin
      bus.start_req  = (m_st == 0) && ($urandom_range(0, 7) == 0);
      bus.stop_req   = ($urandom_range(0, 99) == 0);
      bus.clr_err    = ($urandom_range(0, 59) == 0);
      bus.wr_commit  = (m_st != 0) && ($urandom_range(0, 3) != 0);
      bus.fifo_count = 9'($urandom_range(0, 3));
      if ($urandom_range(0, 199) == 0) bus.irq_thresh = 15'($urandom_range(0, 200));
      if ($urandom_range(0, 7) == 0) begin
        bus.rd_ptr_upd = 1'b1;
        bus.rd_ptr     = 14'((m_rdq + int'($urandom_range(0, m_fill + 6))) % D);
      end
      tick();
    end
    stop_and_drain();
    bus.clr_err = 1'b1;
    tick();

    // Asynchronous reset during RUN
    bus.irq_thresh = 15'd64;
    start();
    commit_n(100);
    check("rst_pre_irq", int'(bus.irq), 1);
    check("rst_pre_gen", int'(bus.gen_enable), 1);
    #2;
    rst = 1'b1;
    #1;
    check("rst_state", int'(bus.state), 0);
    check("rst_gen", int'(bus.gen_enable), 0);
    check("rst_buf", int'(bus.buf_reset), 0);
    check("rst_fill", int'(bus.fill_level), 0);
    check("rst_irq", int'(bus.irq), 0);
    check("rst_ovr", int'(bus.overrun), 0);
    check("rst_rderr", int'(bus.rd_err), 0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    repeat (3) tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/bram_ring_ctrl.md
BRAM_RING_CTRL -- requirements
Module: bram_ring_ctrl

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 16384: ring buffer depth in 32-bit words.
REQ-002 SHALL have parameter PTR_W, default 14: word pointer width, equal to log2(DEPTH_WORDS).
REQ-003 SHALL have parameter PACKET_WORDS, default 144: words per generator packet.
REQ-004 Port clk, input, 1: single clock; all logic is on clk.
REQ-005 Port rst, input, 1: asynchronous, active-high reset.
REQ-006 Port start_req, input, 1: one-cycle pulse requesting acquisition start.
REQ-007 Port stop_req, input, 1: one-cycle pulse requesting acquisition stop.
REQ-008 Port clr_err, input, 1: pulse that clears the sticky error flags.
REQ-009 Port wr_commit, input, 1: one-cycle pulse per word written to BRAM by the FIFO-BRAM writer.
REQ-010 Port fifo_count, input, 9: FIFO occupancy from the writer.
REQ-011 Port rd_ptr_upd, input, 1: strobe from the PS indicating that rd_ptr is valid.
REQ-012 Port rd_ptr, input, PTR_W: PS consumed word address (next word to be read).
REQ-013 Port irq_thresh, input, PTR_W+1: fill level at or above which irq asserts.
REQ-014 Port gen_enable, output, 1: enables the data generator core.
REQ-015 Port buf_reset, output, 1: one-cycle pulse that resets the writer BRAM address to 0.
REQ-016 Port fill_level, output, PTR_W+1: number of unread words, in the range 0..DEPTH_WORDS.
REQ-017 Port irq, output, 1: level-sensitive interrupt.
REQ-018 Port overrun, output, 1: sticky flag.
REQ-019 Port rd_err, output, 1: sticky flag.
REQ-020 Port state, output, 2: encoded FSM state for the status register.

Function
REQ-021 The FSM SHALL have exactly four states:
- IDLE=0
- RUN=1
- STOPPING=2
- FLUSH=3
REQ-022 In IDLE, a start_req SHALL produce the following on the next cycle, and the FSM SHALL enter RUN:
- buf_reset=1 for one cycle
- fill_level=0
- word counter=0
- internal rd_ptr_q=0
REQ-023 gen_enable SHALL be registered and SHALL equal 1 exactly while the state is RUN or STOPPING.
REQ-024 The word counter SHALL increment on each wr_commit and SHALL wrap from PACKET_WORDS-1 to 0.
- A "packet boundary" is a cycle in which the counter is 0 and wr_commit is 0.
REQ-025 In RUN, a stop_req SHALL move the FSM to STOPPING.
REQ-026 In STOPPING, the FSM SHALL go to FLUSH at the first packet boundary, or immediately if the counter is already 0.
REQ-027 In FLUSH, the FSM SHALL return to IDLE in the first cycle in which fifo_count==0 and wr_commit==0.
REQ-028 start_req SHALL be ignored outside IDLE, and stop_req SHALL be ignored outside RUN.
REQ-029 If start_req and stop_req arrive in the same IDLE cycle, the FSM SHALL remain in IDLE.
REQ-030 On rd_ptr_upd, consumed SHALL be computed as (rd_ptr - rd_ptr_q) mod DEPTH_WORDS, and rd_ptr_q SHALL be loaded with rd_ptr.
REQ-031 fill_level SHALL be updated as fill_level + wr_commit - consumed in a single cycle, so that simultaneous commit and update are both honoured.
REQ-032 If consumed exceeds fill_level + wr_commit, fill_level SHALL become 0 and rd_err SHALL be set.
REQ-033 In RUN, if fill_level exceeds DEPTH_WORDS - PACKET_WORDS at a packet boundary:
- overrun SHALL be set
- gen_enable SHALL drop on the next cycle
- the FSM SHALL go to FLUSH
REQ-034 fill_level SHALL saturate at DEPTH_WORDS; any wr_commit at saturation SHALL set overrun.
REQ-035 irq SHALL be registered and SHALL equal 1 when the state is not IDLE and fill_level >= irq_thresh.
- irq_thresh=0 SHALL disable irq.
REQ-036 A start_req SHALL be ignored while overrun or rd_err is set.
REQ-037 clr_err SHALL clear both sticky flags; if clr_err coincides with a new error, the set SHALL win.
REQ-038 rd_ptr_upd SHALL be accepted in every state; in IDLE, it SHALL update only rd_ptr_q.

Reset
REQ-039 rst SHALL asynchronously force the following:
- state=IDLE
- gen_enable=0
- buf_reset=0
- fill_level=0
- word counter=0
- rd_ptr_q=0
- irq=0
- overrun=0
- rd_err=0
REQ-040 Reset asserted during RUN SHALL drop gen_enable without a packet-boundary wait.

Structure
REQ-041 A shared package SHALL hold:
- the state encoding
- DEPTH_WORDS, PTR_W and PACKET_WORDS defaults
- the status-register bit positions of state, overrun and rd_err
REQ-042 The fill/pointer arithmetic SHALL be one sub-module, ring_fill_tracker.
- Its inputs are wr_commit, rd_ptr_upd, rd_ptr and clear.
- Its outputs are fill_level, overrun_evt and rd_err_evt.
REQ-043 The FSM and the packet counter SHALL reside in bram_ring_ctrl.

Verification
REQ-044 Nominal run: start_req, then 288 wr_commit, then rd_ptr=144 -> fill_level goes 288 then 144; buf_reset pulses once; state=1.
REQ-045 Stop mid-packet: stop_req after 150 commits -> gen_enable stays 1 until commit 288, then state=3; IDLE follows once fifo_count=0.
REQ-046 Overrun: 16241 commits with no reads -> overrun=1 at the packet boundary, gen_enable=0, state=3; a subsequent start_req is ignored until clr_err.
REQ-047 Wrap and simultaneous events: fill_level=100, rd_ptr_q=16380, then rd_ptr=4 together with wr_commit -> consumed=8, fill_level=93.
REQ-048 Read error: fill_level=10, rd_ptr advanced by 20 -> fill_level=0, rd_err=1; clr_err clears it.
REQ-049 Reset mid-RUN: with irq_thresh=64 and fill_level=100 (irq=1), assert rst -> all outputs reach their reset values asynchronously, before the next clk edge.
